// File: rtl/uart_tx_framer_if.sv
// Upstream pull interface for the UART TX framer: request/available handshake plus per-word frame format.
// Master is the upstream FIFO side, slave is the framer.
interface uart_tx_framer_if #(
    parameter int DATA_BITS = 8
);
    logic                 data_available;
    logic [DATA_BITS-1:0] data;
    logic [1:0]           parity_mode;
    logic                 two_stop;
    logic                 req;

    modport master (
        output data_available,
        output data,
        output parity_mode,
        output two_stop,
        input  req
    );

    modport slave (
        input  data_available,
        input  data,
        input  parity_mode,
        input  two_stop,
        output req
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART TX framer: start, DATA_BITS LSB-first, optional parity, 1/2 stop bits; bits advance on ser_clk_posedge.
// Latency: req one clk after data_available, start bit on the first tick after capture; upstream is pulled only when idle.
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ser_clk_posedge,
    uart_tx_framer_if.slave up,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);
    localparam int CW = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_START   = 3'd4;
    localparam logic [2:0] S_DATA    = 3'd5;
    localparam logic [2:0] S_PARITY  = 3'd6;
    localparam logic [2:0] S_STOP    = 3'd7;

    logic [2:0]           state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [CW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 two_stop_q, two_stop_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q,       tx_d;
    logic                 done_q,     done_d;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (up.data_available) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Format is frozen here with the word; later changes apply to the next frame only.
                shift_d    = up.data;
                par_en_d   = |up.parity_mode;
                two_stop_d = up.two_stop;
                case (up.parity_mode)
                    2'b01:   par_bit_d = ~^up.data;
                    2'b10:   par_bit_d = ^up.data;
                    2'b11:   par_bit_d = 1'b1;
                    default: par_bit_d = 1'b0;
                endcase
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ser_clk_posedge) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (ser_clk_posedge) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CW'(DATA_BITS - 1);
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (ser_clk_posedge) begin
                    if (bit_cnt_q == '0) begin
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = two_stop_q;
                            state_d    = S_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (ser_clk_posedge) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = two_stop_q;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                // stop_cnt_q set means one more stop period remains after this tick.
                if (ser_clk_posedge) begin
                    if (stop_cnt_q) begin
                        stop_cnt_d = 1'b0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // tx_q holds the logical level; an inverted line flips it at the pin.
    assign tx         = tx_q ^ ~IDLE_LEVEL;
    assign up.req     = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;

endmodule
